// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller for a single-port 32x256 SRAM macro, with a 2-entry output buffer.
// Optional SRAM_FIFO_BYPASS_EN: pushes into an empty FIFO skip the SRAM and land directly in the buffer.
module sram_fifo_ctrl #(
  parameter int BPW  = 32,
  parameter int WORD = 256,
  parameter int ADDR = $clog2(WORD)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BPW-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BPW-1:0]  out_data,
  output logic [ADDR:0]   count,
  output logic            full,
  output logic            empty,
  output logic            CEN,
  output logic            WEN,
  output logic [ADDR-1:0] A,
  output logic [BPW-1:0]  D,
  input  logic [BPW-1:0]  Q
);

  logic [ADDR-1:0] wr_ptr, rd_ptr;
  logic [ADDR:0]   mem_cnt;
  logic            inflight;
  logic [1:0]      ob_cnt;
  logic [BPW-1:0]  ob [2];

  logic            full_i, rd_go, rd_issue, push, byp, wr_go, pop, ob_wr;
  logic [BPW-1:0]  ob_wdata;
  logic [ADDR:0]   count_i;

  // Read eligibility looks only at registered state, so in_ready has no path from in_valid/out_ready.
  assign full_i   = (mem_cnt == (ADDR+1)'(WORD));
  assign rd_go    = (mem_cnt != '0) && (({1'b0, ob_cnt} + 3'(inflight)) < 3'd2);
  assign rd_issue = !RST && rd_go;
  assign in_ready = !RST && !full_i && !rd_go;
  assign push     = in_valid && in_ready;

`ifdef SRAM_FIFO_BYPASS_EN
  assign byp = push && (mem_cnt == '0) && !inflight && (ob_cnt != 2'd2);
`else
  assign byp = 1'b0;
`endif

  assign wr_go    = push && !byp;
  assign out_valid = !RST && (ob_cnt != 2'd0);
  assign pop      = out_valid && out_ready;
  assign ob_wr    = inflight || byp;
  assign ob_wdata = inflight ? Q : in_data;
  assign out_data = ob[0];

  assign CEN = !(rd_issue || wr_go);
  assign WEN = !wr_go;
  assign A   = rd_issue ? rd_ptr : (wr_go ? wr_ptr : '0);
  assign D   = wr_go ? in_data : '0;

  assign count_i = mem_cnt + (ADDR+1)'(inflight) + (ADDR+1)'(ob_cnt);
  assign count   = RST ? '0 : count_i;
  assign empty   = (count == '0);
  assign full    = !RST && full_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + ADDR'(1);
        mem_cnt <= mem_cnt - (ADDR+1)'(1);
      end else if (wr_go) begin
        wr_ptr  <= wr_ptr + ADDR'(1);
        mem_cnt <= mem_cnt + (ADDR+1)'(1);
      end
      inflight <= rd_issue;
      case ({ob_wr, pop})
        2'b10:   ob_cnt <= ob_cnt + 2'd1;
        2'b01:   ob_cnt <= ob_cnt - 2'd1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  // NOTE: buffer payload needs no reset; ob_cnt alone decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (pop) begin
      if (ob_wr && ob_cnt == 2'd2) begin
        ob[0] <= ob[1];
        ob[1] <= ob_wdata;
      end else if (ob_wr) begin
        ob[0] <= ob_wdata;
      end else begin
        ob[0] <= ob[1];
      end
    end else if (ob_wr) begin
      ob[ob_cnt[0]] <= ob_wdata;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: SRAM macro model plus a queue-based cycle reference model.
module tb_sram_fifo_ctrl;
  localparam int BPW  = 32;
  localparam int WORD = 256;
  localparam int ADDR = 8;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            CLK, RST, in_valid, in_ready, out_valid, out_ready, full, empty, CEN, WEN;
  logic [BPW-1:0]  in_data, out_data, D, Q;
  logic [ADDR:0]   count;
  logic [ADDR-1:0] A;

  sram_fifo_ctrl #(.BPW(BPW), .WORD(WORD), .ADDR(ADDR)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .full(full), .empty(empty), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM macro: Q is meaningful only in the cycle after a read; otherwise it carries junk.
  logic [BPW-1:0] sram [WORD];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) sram[A] <= D;
      else      Q <= sram[A];
    end else begin
      Q <= $urandom;
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model: words sit in the SRAM queue, a one-slot read pipe, then the output queue.
  logic [BPW-1:0] mem_q[$];
  logic [BPW-1:0] infl_q[$];
  logic [BPW-1:0] ob_q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int accepted;
  int next_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [BPW-1:0] din, input bit ordy);
    bit rd_go, push, byp, wr, pop;
    bit e_ir, e_ov, e_full, e_cen, e_wen;
    int e_cnt, e_a;
    logic [BPW-1:0] e_d, cap;
    @(negedge CLK);
    RST = rst; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    accepted = 0;
    if (rst) begin
      rd_go = 0; push = 0; byp = 0; wr = 0; pop = 0;
      e_ir = 0; e_ov = 0; e_cnt = 0; e_full = 0; e_cen = 1; e_wen = 1; e_a = 0; e_d = '0;
    end else begin
      rd_go  = mem_q.size() != 0 && (ob_q.size() + infl_q.size()) < 2;
      e_full = mem_q.size() == WORD;
      e_ir   = !e_full && !rd_go;
      push   = iv && e_ir;
      byp    = BYP && push && mem_q.size() == 0 && infl_q.size() == 0 && ob_q.size() < 2;
      wr     = push && !byp;
      e_ov   = ob_q.size() != 0;
      pop    = e_ov && ordy;
      e_cnt  = mem_q.size() + infl_q.size() + ob_q.size();
      e_cen  = !(rd_go || wr);
      e_wen  = !wr;
      e_a    = rd_go ? rd_cnt % WORD : (wr ? wr_cnt % WORD : 0);
      e_d    = wr ? din : '0;
    end
    check("in_ready", in_ready, e_ir);
    check("out_valid", out_valid, e_ov);
    if (e_ov) check("out_data", out_data, ob_q[0]);
    check("count", count, e_cnt);
    check("full", full, e_full);
    check("empty", empty, e_cnt == 0);
    check("CEN", CEN, e_cen);
    check("WEN", WEN, e_wen);
    check("A", A, e_a);
    check("D", D, e_d);
    if (rst) begin
      mem_q.delete(); infl_q.delete(); ob_q.delete();
      wr_cnt = 0; rd_cnt = 0;
    end else begin
      accepted = push;
      if (pop) void'(ob_q.pop_front());
      if (infl_q.size() != 0) begin
        cap = infl_q.pop_front();
        ob_q.push_back(cap);
      end
      if (byp) ob_q.push_back(din);
      if (rd_go) begin
        infl_q.push_back(mem_q.pop_front());
        rd_cnt++;
      end
      if (wr) begin
        mem_q.push_back(din);
        wr_cnt++;
      end
    end
  endtask

  initial begin
    bit reached;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Single word, held until well after it reaches the buffer, then popped.
    step(0, 1, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);

    // Fill past capacity with the consumer stalled.
    next_val = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 1, next_val, 0);
      if (accepted != 0) next_val++;
    end

    // Drain everything in order.
    for (int i = 0; i < 280; i++) step(0, 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) step(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0);

    // Continuous push and pop: several pointer wraps.
    for (int i = 0; i < 1500; i++) step(0, 1, $urandom, 1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1);

    // Reset while a read is in flight; its Q must not reach the buffer.
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step(0, 1, $urandom, i % 3 == 2);
      if (infl_q.size() == 1 && ob_q.size() >= 1) reached = 1;
    end
    check("reach_inflight", reached, 1'b1);
    step(1, 1, $urandom, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

    // Traffic after reset restarts cleanly at address 0.
    for (int i = 0; i < 200; i++) step(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
